tt_ran_arbiter: RTL and testbench

Scheduler for the random-bit post-processing path. It takes raw entropy samples and removes bias with von Neumann pairing. Debiased bits are packed into WORD_W-bit words. Finished words go to NREQ requesters under round-robin arbitration. A repetition-count health test blocks all grants once the source appears stuck.

---
 rtl/tt_ran_arbiter_if.sv | 35 +++
 rtl/tt_ran_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_tt_ran_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tt_ran_arbiter_if.sv
// rtl/tt_ran_arbiter_if.sv - bus bundle between requesters/entropy source and the random-word arbiter
//
// Signals:
//   raw_valid, raw_bit : raw entropy sample and its strobe (source -> arbiter)
//   flush              : synchronous discard of partial word and pair state (source -> arbiter)
//   req                : per-requester level word request (requesters -> arbiter)
//   gnt                : one-hot single-cycle grant (arbiter -> requesters)
//   word_out           : delivered word, zero unless word_valid (arbiter -> requesters)
//   word_valid         : high for exactly the grant cycle (arbiter -> requesters)
//   health_fail        : sticky stuck-source flag (arbiter -> requesters)
// Modports: master drives stimulus and requests, slave is the arbiter.

interface tt_ran_arbiter_if #(
    parameter int NREQ   = 2,
    parameter int WORD_W = 8
);
    logic              raw_valid;
    logic              raw_bit;
    logic              flush;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   gnt;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              health_fail;

    modport master (
        output raw_valid, raw_bit, flush, req,
        input  gnt, word_out, word_valid, health_fail
    );

    modport slave (
        input  raw_valid, raw_bit, flush, req,
        output gnt, word_out, word_valid, health_fail
    );
endinterface

// File: rtl/tt_ran_arbiter.sv
// rtl/tt_ran_arbiter.sv - von Neumann debiaser, word packer and round-robin word arbiter with repetition-count health test
//
// Ports:
//   clk   : system clock
//   rst_n : asynchronous reset, active-high (1 = reset)
//   bus   : tt_ran_arbiter_if.slave (raw_valid, raw_bit, flush, req in; gnt, word_out,
//           word_valid, health_fail out)
// Parameters: NREQ requesters (2..4), WORD_W bits per word, REP_LIMIT run length that
// declares a stuck source (2..255).

module tt_ran_arbiter #(
    parameter int NREQ      = 2,
    parameter int WORD_W    = 8,
    parameter int REP_LIMIT = 8
) (
    input logic            clk,
    input logic            rst_n,
    tt_ran_arbiter_if.slave bus
);
    localparam int PTR_W = (NREQ > 2) ? 2 : 1;
    localparam int CNT_W = $clog2(WORD_W);

    typedef enum logic [1:0] {FILL, READY, GRANT, FAULT} state_t;

    state_t            state;
    state_t            state_next;

    logic [WORD_W-1:0] word_buf;
    logic [CNT_W-1:0]  bit_cnt;
    logic              pair_flag;
    logic              first_bit;

    logic [7:0]        run_cnt;
    logic [7:0]        run_next;
    logic              last_bit;

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  winner;
    logic              found;

    logic [NREQ-1:0]   gnt_q;
    logic [WORD_W-1:0] word_out_q;
    logic              word_valid_q;
    logic              health_fail_q;

    logic              sample;
    logic              fault_now;
    logic              last_slot;
    logic              pair_adv;
    logic              store_bit;
    logic              buf_clear;
    logic              load_gnt;

    // Health test watches every sample until the block is latched in FAULT.
    assign sample    = bus.raw_valid && (state != FAULT);
    assign last_slot = (bit_cnt == CNT_W'(WORD_W - 1));

    always_comb begin
        run_next = 8'd1;
        if (run_cnt != 8'd0 && bus.raw_bit == last_bit) begin
            if (run_cnt >= 8'(REP_LIMIT)) begin
                run_next = 8'(REP_LIMIT);
            end else begin
                run_next = run_cnt + 8'd1;
            end
        end
    end

    assign fault_now = sample && (run_next == 8'(REP_LIMIT));

    // First asserted request at or after the pointer, wrapping upward.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            int idx;
            idx = (int'(rr_ptr) + i) % NREQ;
            if (!found && bus.req[idx]) begin
                winner = PTR_W'(idx);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pair_adv   = 1'b0;
        store_bit  = 1'b0;
        buf_clear  = 1'b0;
        load_gnt   = 1'b0;
        unique case (state)
            FILL: begin
                if (bus.flush) begin
                    buf_clear = 1'b1;
                end else if (bus.raw_valid) begin
                    pair_adv = 1'b1;
                    if (pair_flag && bus.raw_bit != first_bit) begin
                        store_bit = 1'b1;
                        if (last_slot) begin
                            state_next = READY;
                        end
                    end
                end
            end
            READY: begin
                if (bus.flush) begin
                    buf_clear  = 1'b1;
                    state_next = FILL;
                end else if (found) begin
                    load_gnt   = 1'b1;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                buf_clear  = 1'b1;
                state_next = FILL;
            end
            FAULT: begin
                buf_clear = 1'b1;
            end
            default: begin
                state_next = FILL;
            end
        endcase
        // A stuck source overrides any word completion or grant decision this cycle.
        if (fault_now) begin
            state_next = FAULT;
            pair_adv   = 1'b0;
            store_bit  = 1'b0;
            load_gnt   = 1'b0;
            buf_clear  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            word_buf  <= '0;
            bit_cnt   <= '0;
            pair_flag <= 1'b0;
            first_bit <= 1'b0;
        end else if (buf_clear) begin
            word_buf  <= '0;
            bit_cnt   <= '0;
            pair_flag <= 1'b0;
            first_bit <= 1'b0;
        end else begin
            if (state != FILL) begin
                pair_flag <= 1'b0;
            end else if (pair_adv) begin
                pair_flag <= ~pair_flag;
                if (!pair_flag) begin
                    first_bit <= bus.raw_bit;
                end
            end
            if (store_bit) begin
                word_buf[bit_cnt] <= first_bit;
                bit_cnt           <= last_slot ? '0 : bit_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            run_cnt       <= 8'd0;
            last_bit      <= 1'b0;
            health_fail_q <= 1'b0;
        end else begin
            if (sample) begin
                run_cnt  <= run_next;
                last_bit <= bus.raw_bit;
            end
            if (fault_now) begin
                health_fail_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rr_ptr       <= '0;
            gnt_q        <= '0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
        end else begin
            gnt_q        <= load_gnt ? (NREQ'(1) << winner) : '0;
            word_out_q   <= load_gnt ? word_buf : '0;
            word_valid_q <= load_gnt;
            if (load_gnt) begin
                rr_ptr <= (winner == PTR_W'(NREQ - 1)) ? '0 : winner + PTR_W'(1);
            end
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.word_out    = word_out_q;
    assign bus.word_valid  = word_valid_q;
    assign bus.health_fail = health_fail_q;

endmodule

// File: tb/tb_tt_ran_arbiter.sv
// tb/tb_tt_ran_arbiter.sv - scoreboard bench for tt_ran_arbiter

module tb_tt_ran_arbiter;
    localparam int NREQ      = 2;
    localparam int WORD_W    = 8;
    localparam int REP_LIMIT = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    tt_ran_arbiter_if #(.NREQ(NREQ), .WORD_W(WORD_W)) bus ();

    tt_ran_arbiter #(.NREQ(NREQ), .WORD_W(WORD_W), .REP_LIMIT(REP_LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [NREQ+WORD_W-1:0] exp_q[$];
    bit                     model_samples[$];
    int                     model_ptr;
    int                     model_run;
    bit                     model_last;
    bit                     model_fault;
    bit                     allow_gap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
        end
    endtask

    function automatic int vn_count();
        int k = 0;
        for (int i = 0; i + 1 < model_samples.size(); i += 2)
            if (model_samples[i] != model_samples[i+1]) k++;
        return k;
    endfunction

    function automatic logic [WORD_W-1:0] vn_extract();
        logic [WORD_W-1:0] w = '0;
        int k = 0;
        for (int i = 0; i + 1 < model_samples.size(); i += 2) begin
            if (model_samples[i] != model_samples[i+1] && k < WORD_W) begin
                w[k] = model_samples[i];
                k++;
            end
        end
        return w;
    endfunction

    task automatic model_reset();
        model_ptr   = 0;
        model_run   = 0;
        model_last  = 1'b0;
        model_fault = 1'b0;
        model_samples.delete();
    endtask

    task automatic drive_sample(input bit b);
        if (allow_gap && $urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
        end
        bus.raw_valid = 1'b1;
        bus.raw_bit   = b;
        @(posedge clk); #1;
        bus.raw_valid = 1'b0;
        bus.raw_bit   = $urandom_range(0, 1);
        if (!model_fault) begin
            model_samples.push_back(b);
            if (model_run > 0 && b == model_last) begin
                if (model_run < REP_LIMIT) model_run++;
            end else begin
                model_run = 1;
            end
            model_last = b;
            if (model_run == REP_LIMIT) model_fault = 1'b1;
        end
    endtask

    task automatic drive_bits(input logic [WORD_W-1:0] w, input int nbits, input bit discards);
        bit x;
        for (int k = 0; k < nbits; k++) begin
            if (discards && $urandom_range(0, 2) == 0) begin
                x = $urandom_range(0, 1);
                drive_sample(x);
                drive_sample(x);
            end
            drive_sample(w[k]);
            drive_sample(~w[k]);
        end
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        model_samples.delete();
    endtask

    task automatic request(input logic [NREQ-1:0] mask, input string name);
        bit expect_g;
        bit seen;
        int cyc;
        int win;
        expect_g = !model_fault && vn_count() >= WORD_W;
        if (expect_g) begin
            win = -1;
            for (int i = 0; i < NREQ; i++)
                if (win < 0 && mask[(model_ptr + i) % NREQ]) win = (model_ptr + i) % NREQ;
            exp_q.push_back({NREQ'(1) << win, vn_extract()});
            model_ptr = (win + 1) % NREQ;
        end
        bus.req = mask;
        seen = 1'b0;
        cyc  = 0;
        repeat (6) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.gnt != '0) begin
                seen = 1'b1;
                break;
            end
        end
        bus.req = '0;
        if (expect_g) begin
            check({name, "_grant_seen"}, 32'(seen), 32'd1);
            if (seen) check({name, "_grant_latency"}, 32'(cyc), 32'd1);
            model_samples.delete();
        end else begin
            check({name, "_no_grant"}, 32'(seen), 32'd0);
        end
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor: every expected delivery must appear in order, nothing else may.
    always @(negedge clk) begin
        logic [NREQ+WORD_W-1:0] e;
        if (rst_n === 1'b1) begin
            checks++;
            if (bus.gnt != '0 || bus.word_out != '0 || bus.word_valid || bus.health_fail) begin
                errors++;
                $display("FAIL reset_outputs gnt=%b word=%h valid=%b hf=%b required all 0",
                         bus.gnt, bus.word_out, bus.word_valid, bus.health_fail);
            end
        end else if (rst_n === 1'b0) begin
            checks++;
            if (bus.health_fail !== model_fault) begin
                errors++;
                $display("FAIL health_flag actual=%b required=%b", bus.health_fail, model_fault);
            end
            checks++;
            if (bus.word_valid) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_grant gnt=%b word=%h required none", bus.gnt, bus.word_out);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.gnt, bus.word_out} !== e) begin
                        errors++;
                        $display("FAIL grant_word actual gnt=%b word=%h required gnt=%b word=%h",
                                 bus.gnt, bus.word_out, e[NREQ+WORD_W-1:WORD_W], e[WORD_W-1:0]);
                    end
                end
            end else if (bus.gnt != '0 || bus.word_out != '0) begin
                errors++;
                $display("FAIL idle_outputs gnt=%b word=%h required 0", bus.gnt, bus.word_out);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int gseen;
        logic [WORD_W-1:0] w;
        bus.raw_valid = 1'b0;
        bus.raw_bit   = 1'b0;
        bus.flush     = 1'b0;
        bus.req       = '0;
        allow_gap     = 1'b0;
        model_reset();
        rst_n = 1'b1;

        // 1: reset with random inputs, then idle with no samples
        repeat (6) begin
            bus.raw_valid = $urandom_range(0, 1);
            bus.raw_bit   = $urandom_range(0, 1);
            bus.req       = NREQ'($urandom_range(0, 3));
            @(posedge clk); #1;
            check("reset_gnt", 32'(bus.gnt), 32'd0);
            check("reset_word_valid", 32'(bus.word_valid), 32'd0);
        end
        bus.raw_valid = 1'b0;
        bus.req       = '0;
        rst_n = 1'b0;
        gseen = 0;
        repeat (20) begin
            bus.req = NREQ'($urandom_range(0, 3));
            @(posedge clk); #1;
            if (bus.gnt != '0) gseen++;
        end
        bus.req = '0;
        check("idle_no_grant", 32'(gseen), 32'd0);
        @(posedge clk); #1;

        // 2: fixed 0x4D word to requester 0
        drive_bits(8'h4D, 8, 1'b0);
        request(2'b01, "t2");

        // 3: both requesting, three words, pointer wraps
        drive_bits(8'h4D, 8, 1'b0);
        request(2'b11, "t3a");
        drive_bits(8'h4D, 8, 1'b0);
        request(2'b11, "t3b");
        drive_bits(8'h4D, 8, 1'b0);
        request(2'b11, "t3c");

        // 4: discard pairs interleaved
        drive_bits(8'hA6, 8, 1'b1);
        request(2'b10, "t4");

        // 6: flush of a partial word, then flush racing a request in READY
        drive_bits(8'h1F, 5, 1'b0);
        do_flush();
        drive_bits(8'hC3, 8, 1'b0);
        request(2'b11, "t6a");
        drive_bits(8'h5A, 8, 1'b0);
        bus.req   = 2'b11;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.req   = '0;
        bus.flush = 1'b0;
        model_samples.delete();
        check("t6_flush_beats_req", 32'(bus.gnt), 32'd0);
        request(2'b11, "t6_after_flush");

        // randomized words, masks, gaps and held-word delays
        allow_gap = 1'b1;
        for (int n = 0; n < 14; n++) begin
            w = WORD_W'($urandom);
            drive_bits(w, 8, 1'b1);
            repeat ($urandom_range(0, 4)) begin
                @(posedge clk); #1;
            end
            request(NREQ'($urandom_range(1, 3)), "rand");
        end
        allow_gap = 1'b0;

        // 5: stuck source
        drive_sample(1'b0);
        for (int i = 0; i < REP_LIMIT - 1; i++) drive_sample(1'b1);
        check("t5_hf_before_limit", 32'(bus.health_fail), 32'd0);
        drive_sample(1'b1);
        check("t5_hf_after_limit", 32'(bus.health_fail), 32'd1);
        drive_bits(8'h4D, 8, 1'b0);
        request(2'b11, "t5_fault");
        do_flush();
        check("t5_hf_sticky", 32'(bus.health_fail), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        check("t5_async_reset_hf", 32'(bus.health_fail), 32'd0);
        check("t5_async_reset_gnt", 32'(bus.gnt), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        drive_bits(8'h96, 8, 1'b0);
        request(2'b10, "t5_after_reset");

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
